// File: rtl/pkg_config.sv
// Core-wide configuration shared by the RV32I pipeline blocks.
// Also defines the writeback request bundle used by the arbiter.
package pkg_config;

  localparam int DATA_WIDTH     = 32;
  localparam int NUM_REGISTER   = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGISTER);

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]     data;
  } wb_req_t;

  function automatic logic is_x0(input logic [REG_ADDR_WIDTH-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue
// and cleared on retire. Also provides WAW issue gating and RAW busy lookups.
module regfile_scoreboard
  import pkg_config::*;
(
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      issue_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd_addr_i,
  output logic                      issue_ready_o,
  input  logic                      retire_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] retire_rd_addr_i,
  output logic                      retire_pending_o,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic                      rs1_busy_o,
  output logic                      rs2_busy_o
);

  logic [NUM_REGISTER-1:0] pending_q;
  logic [NUM_REGISTER-1:0] pending_d;
  logic                    retire_same_rd;
  logic                    issue_fire;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    retire_same_rd = retire_valid_i && (retire_rd_addr_i == issue_rd_addr_i);
    issue_ready_o  = !pending_q[issue_rd_addr_i] || retire_same_rd
                     || is_x0(issue_rd_addr_i);
    issue_fire     = issue_valid_i && issue_ready_o;

    pending_d = pending_q;
    if (retire_valid_i) begin
      pending_d[retire_rd_addr_i] = 1'b0;
    end
    // Applied after the clear so a same-register issue keeps the bit set.
    if (issue_fire) begin
      pending_d[issue_rd_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // NOTE: the pending bits are control state, not data storage, so they are
  // reset; a mid-flight reset must drop every outstanding write. Sequential
  // state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign retire_pending_o = pending_q[retire_rd_addr_i];
  assign rs1_busy_o       = pending_q[rs1_addr_i];
  assign rs2_busy_o       = pending_q[rs2_addr_i];

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates LSU/ALU results (LSU first), registers the
// register-file write, drives bypass/hazard signals and a sticky error flag.
module regfile_writeback
  import pkg_config::*;
(
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      issue_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd_addr_i,
  output logic                      issue_ready_o,
  input  logic                      lsu_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     lsu_data_i,
  output logic                      lsu_ready_o,
  input  logic                      alu_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     alu_data_i,
  output logic                      alu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic                      rs1_busy_o,
  output logic                      rs2_busy_o,
  output logic                      rs1_fwd_o,
  output logic                      rs2_fwd_o,
  output logic [DATA_WIDTH-1:0]     fwd_data_o,
  output logic                      we_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic                      error_o
);

  wb_req_t                   sel;
  logic                      retire_pending;
  logic                      we_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0]     rd_data_q;
  logic                      error_q;

  assign lsu_ready_o = 1'b1;
  assign alu_ready_o = !lsu_valid_i;

  // Fixed priority: a valid load always wins and the ALU is held off.
  always_comb begin
    sel = '0;
    if (lsu_valid_i) begin
      sel.valid   = 1'b1;
      sel.rd_addr = lsu_rd_addr_i;
      sel.data    = lsu_data_i;
    end else if (alu_valid_i) begin
      sel.valid   = 1'b1;
      sel.rd_addr = alu_rd_addr_i;
      sel.data    = alu_data_i;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .issue_valid_i    (issue_valid_i),
    .issue_rd_addr_i  (issue_rd_addr_i),
    .issue_ready_o    (issue_ready_o),
    .retire_valid_i   (sel.valid),
    .retire_rd_addr_i (sel.rd_addr),
    .retire_pending_o (retire_pending),
    .rs1_addr_i       (rs1_addr_i),
    .rs2_addr_i       (rs2_addr_i),
    .rs1_busy_o       (rs1_busy_o),
    .rs2_busy_o       (rs2_busy_o)
  );

  // Address and data hold when nothing retires; only we_o drops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      we_q <= sel.valid && !is_x0(sel.rd_addr);
      if (sel.valid) begin
        rd_addr_q <= sel.rd_addr;
        rd_data_q <= sel.data;
      end
    end
  end

  // A retire with no matching issue is a pipeline bookkeeping bug; the write
  // is still performed and the flag stays set until reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      error_q <= 1'b0;
    end else if (sel.valid && !is_x0(sel.rd_addr) && !retire_pending) begin
      error_q <= 1'b1;
    end
  end

  assign we_o       = we_q;
  assign rd_addr_o  = rd_addr_q;
  assign rd_data_o  = rd_data_q;
  assign fwd_data_o = rd_data_q;
  assign error_o    = error_q;

  assign rs1_fwd_o = we_q && (rd_addr_q == rs1_addr_i) && !is_x0(rs1_addr_i);
  assign rs2_fwd_o = we_q && (rd_addr_q == rs2_addr_i) && !is_x0(rs2_addr_i);

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: issue/retire latency, arbitration,
// WAW gating, x0 handling, sticky error and asynchronous reset.
module tb_regfile_writeback;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_addr_i;
  logic        issue_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_data_i;
  logic        lsu_ready_o;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_addr_i;
  logic [31:0] alu_data_i;
  logic        alu_ready_o;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        rs1_fwd_o;
  logic        rs2_fwd_o;
  logic [31:0] fwd_data_o;
  logic        we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        error_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  regfile_writeback dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_addr_i (issue_rd_addr_i),
    .issue_ready_o   (issue_ready_o),
    .lsu_valid_i     (lsu_valid_i),
    .lsu_rd_addr_i   (lsu_rd_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_ready_o     (lsu_ready_o),
    .alu_valid_i     (alu_valid_i),
    .alu_rd_addr_i   (alu_rd_addr_i),
    .alu_data_i      (alu_data_i),
    .alu_ready_o     (alu_ready_o),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_addr_i      (rs2_addr_i),
    .rs1_busy_o      (rs1_busy_o),
    .rs2_busy_o      (rs2_busy_o),
    .rs1_fwd_o       (rs1_fwd_o),
    .rs2_fwd_o       (rs2_fwd_o),
    .fwd_data_o      (fwd_data_o),
    .we_o            (we_o),
    .rd_addr_o       (rd_addr_o),
    .rd_data_o       (rd_data_o),
    .error_o         (error_o)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    issue_valid_i = 1'b0; issue_rd_addr_i = 5'd5;
    lsu_valid_i = 1'b0; lsu_rd_addr_i = '0; lsu_data_i = '0;
    alu_valid_i = 1'b0; alu_rd_addr_i = '0; alu_data_i = '0;
    rs1_addr_i = 5'd5; rs2_addr_i = 5'd0;
    #12;
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    check("rst_rd_data", rd_data_o, 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_issue_ready", 32'(issue_ready_o), 32'd1);
    check("rst_rs1_busy", 32'(rs1_busy_o), 32'd0);
    check("rst_lsu_ready", 32'(lsu_ready_o), 32'd1);
    rst_n_i = 1'b1;
    tick();

    // Issue x5, result arrives 3 cycles after the issue.
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd5; settle();
    check("x5_issue_ready", 32'(issue_ready_o), 32'd1);
    tick();
    issue_valid_i = 1'b0; settle();
    check("x5_busy_n1", 32'(rs1_busy_o), 32'd1);
    tick(); tick();
    alu_valid_i = 1'b1; alu_rd_addr_i = 5'd5; alu_data_i = 32'hDEAD_BEEF; settle();
    check("x5_alu_ready", 32'(alu_ready_o), 32'd1);
    check("x5_busy_n3", 32'(rs1_busy_o), 32'd1);
    tick();
    alu_valid_i = 1'b0; settle();
    check("x5_we", 32'(we_o), 32'd1);
    check("x5_rd_addr", 32'(rd_addr_o), 32'd5);
    check("x5_rd_data", rd_data_o, 32'hDEAD_BEEF);
    check("x5_fwd", 32'(rs1_fwd_o), 32'd1);
    check("x5_fwd_data", fwd_data_o, 32'hDEAD_BEEF);
    check("x5_busy_clear", 32'(rs1_busy_o), 32'd0);
    check("x5_rs2_x0_nofwd", 32'(rs2_fwd_o), 32'd0);
    tick();
    check("x5_we_drop", 32'(we_o), 32'd0);
    check("x5_fwd_drop", 32'(rs1_fwd_o), 32'd0);
    check("x5_data_hold", rd_data_o, 32'hDEAD_BEEF);

    // LSU x3 and ALU x4 in the same cycle: LSU first, ALU next cycle.
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd3; tick();
    issue_rd_addr_i = 5'd4; tick();
    issue_valid_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd3; lsu_data_i = 32'h11;
    alu_valid_i = 1'b1; alu_rd_addr_i = 5'd4; alu_data_i = 32'h22;
    rs1_addr_i = 5'd3; rs2_addr_i = 5'd4; settle();
    check("arb_alu_held", 32'(alu_ready_o), 32'd0);
    check("arb_lsu_ready", 32'(lsu_ready_o), 32'd1);
    tick();
    lsu_valid_i = 1'b0; settle();
    check("arb_first_addr", 32'(rd_addr_o), 32'd3);
    check("arb_first_data", rd_data_o, 32'h11);
    check("arb_first_we", 32'(we_o), 32'd1);
    check("arb_alu_ready_now", 32'(alu_ready_o), 32'd1);
    check("arb_rs1_fwd_x3", 32'(rs1_fwd_o), 32'd1);
    check("arb_rs2_busy_x4", 32'(rs2_busy_o), 32'd1);
    tick();
    alu_valid_i = 1'b0; settle();
    check("arb_second_addr", 32'(rd_addr_o), 32'd4);
    check("arb_second_data", rd_data_o, 32'h22);
    check("arb_second_we", 32'(we_o), 32'd1);
    check("arb_rs2_fwd_x4", 32'(rs2_fwd_o), 32'd1);
    check("arb_rs1_nofwd", 32'(rs1_fwd_o), 32'd0);
    check("arb_rs2_busy_clr", 32'(rs2_busy_o), 32'd0);
    check("arb_no_error", 32'(error_o), 32'd0);
    tick();

    // WAW gating on x7, then issue coinciding with the x7 retire.
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd7; rs1_addr_i = 5'd7; tick();
    settle();
    check("waw_blocked", 32'(issue_ready_o), 32'd0);
    tick();
    alu_valid_i = 1'b1; alu_rd_addr_i = 5'd7; alu_data_i = 32'h77; settle();
    check("waw_same_cycle_ready", 32'(issue_ready_o), 32'd1);
    tick();
    issue_valid_i = 1'b0; alu_data_i = 32'h78; settle();
    check("waw_x7_still_busy", 32'(rs1_busy_o), 32'd1);
    check("waw_x7_we", 32'(we_o), 32'd1);
    check("waw_x7_data", rd_data_o, 32'h77);
    tick();
    alu_valid_i = 1'b0; settle();
    check("waw_x7_busy_clr", 32'(rs1_busy_o), 32'd0);
    check("waw_no_error", 32'(error_o), 32'd0);

    // Issue to x0 never marks it busy.
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd0; rs1_addr_i = 5'd0; tick();
    issue_valid_i = 1'b0; settle();
    check("x0_not_busy", 32'(rs1_busy_o), 32'd0);

    // Retire to x0, then to a non-pending x9.
    alu_valid_i = 1'b1; alu_rd_addr_i = 5'd0; alu_data_i = 32'h55; tick();
    alu_rd_addr_i = 5'd9; alu_data_i = 32'h99; settle();
    check("x0_we", 32'(we_o), 32'd0);
    check("x0_no_error", 32'(error_o), 32'd0);
    check("x0_addr_loaded", 32'(rd_addr_o), 32'd0);
    check("x0_no_fwd", 32'(rs1_fwd_o), 32'd0);
    tick();
    alu_valid_i = 1'b0; settle();
    check("x9_error", 32'(error_o), 32'd1);
    check("x9_we", 32'(we_o), 32'd1);
    check("x9_addr", 32'(rd_addr_o), 32'd9);
    check("x9_data", rd_data_o, 32'h99);
    tick(); tick();
    check("x9_error_sticky", 32'(error_o), 32'd1);

    // Asynchronous reset while a write is presented and x11 is pending.
    issue_valid_i = 1'b1; issue_rd_addr_i = 5'd10; tick();
    issue_rd_addr_i = 5'd11;
    alu_valid_i = 1'b1; alu_rd_addr_i = 5'd10; alu_data_i = 32'hA5A5_0010; tick();
    issue_valid_i = 1'b0; alu_valid_i = 1'b0; rs2_addr_i = 5'd11; settle();
    check("pre_rst_we", 32'(we_o), 32'd1);
    check("pre_rst_x11_busy", 32'(rs2_busy_o), 32'd1);
    rst_n_i = 1'b0; settle();
    check("async_rst_we", 32'(we_o), 32'd0);
    check("async_rst_addr", 32'(rd_addr_o), 32'd0);
    check("async_rst_data", rd_data_o, 32'd0);
    check("async_rst_error", 32'(error_o), 32'd0);
    check("async_rst_x11_busy", 32'(rs2_busy_o), 32'd0);
    tick();
    rst_n_i = 1'b1; issue_valid_i = 1'b1; issue_rd_addr_i = 5'd11; settle();
    check("post_rst_issue_ready", 32'(issue_ready_o), 32'd1);
    tick();
    issue_valid_i = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
